// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/execute/memory/writeback states.
// Optional macro MULT_ITER_EN: MULT waits MULT_CYCLES cycles before the HI/LO write.
module multicycle_ctrl #(
  parameter int ALUOP_W     = 4,
  parameter int MULT_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               branch,
  output logic               ne,
  output logic               irwrite,
  output logic               iord,
  output logic [1:0]         memwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               half,
  output logic               b,
  output logic               lbu,
  output logic               link,
  output logic               jr,
  output logic               spregwrite,
  output logic               busy,
  output logic               illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
    S_ALUWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_JR, S_MULT
  } state_t;

  typedef enum logic [4:0] {
    C_NONE, C_LW, C_LH, C_LB, C_LBU, C_SW, C_SH, C_SB, C_RTYPE, C_JR, C_MULT,
    C_ADDI, C_ORI, C_ANDI, C_XORI, C_LUI, C_SLTI, C_BEQ, C_BNE, C_BLEZ, C_J, C_JAL, C_ILL
  } cls_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] ALU_BLEZ = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4'b0011);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(4'b0100);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4'b0101);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(4'b0110);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(4'b0111);
  localparam logic [ALUOP_W-1:0] ALU_FN   = ALUOP_W'(4'b1111);

  if (MULT_CYCLES < 1) begin : g_bad_mult_cycles
    $error("MULT_CYCLES must be at least 1");
  end

  function automatic cls_t classify(input logic [5:0] op_v, input logic [5:0] funct_v);
    cls_t c;
    case (op_v)
      6'b100011: c = C_LW;
      6'b100001: c = C_LH;
      6'b100000: c = C_LB;
      6'b100100: c = C_LBU;
      6'b101011: c = C_SW;
      6'b101001: c = C_SH;
      6'b101000: c = C_SB;
      6'b001000: c = C_ADDI;
      6'b001101: c = C_ORI;
      6'b001100: c = C_ANDI;
      6'b001110: c = C_XORI;
      6'b001111: c = C_LUI;
      6'b001010: c = C_SLTI;
      6'b000100: c = C_BEQ;
      6'b000101: c = C_BNE;
      6'b000110: c = C_BLEZ;
      6'b000010: c = C_J;
      6'b000011: c = C_JAL;
      6'b000000: begin
        if (funct_v == 6'b001000)      c = C_JR;
        else if (funct_v == 6'b011000) c = C_MULT;
        else                           c = C_RTYPE;
      end
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  state_t state_q, state_d;
  cls_t   class_q, class_d, dec_cls;

`ifdef MULT_ITER_EN
  localparam int CNT_W = $clog2(MULT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign dec_cls = classify(op, funct);

  // Next-state logic; the instruction class is captured only while in DECODE.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
`ifdef MULT_ITER_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE; else state_d = S_FETCH;
      S_DECODE: begin
        class_d = dec_cls;
        case (dec_cls)
          C_LW, C_LH, C_LB, C_LBU, C_SW, C_SH, C_SB:      state_d = S_MEMADR;
          C_JR:                                           state_d = S_JR;
          C_MULT: begin
            state_d = S_MULT;
`ifdef MULT_ITER_EN
            cnt_d   = CNT_W'(MULT_CYCLES - 1);
`endif
          end
          C_RTYPE:                                        state_d = S_EXECUTE;
          C_ADDI, C_ORI, C_ANDI, C_XORI, C_LUI, C_SLTI:   state_d = S_IMMEX;
          C_BEQ, C_BNE, C_BLEZ:                           state_d = S_BRANCH;
          C_J, C_JAL:                                     state_d = S_JUMP;
          default:                                        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (class_q == C_LW || class_q == C_LH || class_q == C_LB || class_q == C_LBU)
          state_d = S_MEMRD;
        else
          state_d = S_MEMWR;
      end
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB; else state_d = S_MEMRD;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH; else state_d = S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_IMMEX:   state_d = S_IMMWB;
      S_MULT: begin
`ifdef MULT_ITER_EN
        if (cnt_q == '0) state_d = S_FETCH;
        else             cnt_d   = cnt_q - CNT_W'(1);
`else
        state_d = S_FETCH;
`endif
      end
      default:   state_d = S_FETCH;
    endcase
  end

  // State, class and multiply counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      class_q <= C_NONE;
`ifdef MULT_ITER_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      class_q <= class_d;
`ifdef MULT_ITER_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  logic       pcwrite_s, irwrite_s, regwrite_s, spregwrite_s, illegal_s;
  logic [1:0] memwrite_s;

  // Per-state output decode; write strobes are gated by reset afterwards.
  always_comb begin
    pcwrite_s = 1'b0; branch = 1'b0; ne = 1'b0; irwrite_s = 1'b0; iord = 1'b0;
    memwrite_s = 2'b00; memtoreg = 1'b0; regdst = 1'b0; regwrite_s = 1'b0;
    alusrca = 1'b0; alusrcb = 2'b00; pcsrc = 2'b00; aluop = ALU_ADD;
    half = 1'b0; b = 1'b0; lbu = 1'b0; link = 1'b0; jr = 1'b0;
    spregwrite_s = 1'b0; illegal_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb   = 2'b01;
        irwrite_s = mem_ready;
        pcwrite_s = mem_ready;
      end
      S_DECODE: begin
        alusrcb   = 2'b11;
        illegal_s = (dec_cls == C_ILL);
      end
      S_MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
        half       = (class_q == C_LH) || (class_q == C_LB);
        b          = (class_q == C_LB);
        lbu        = (class_q == C_LBU);
      end
      S_MEMWR: begin
        iord = 1'b1;
        case (class_q)
          C_SW:    memwrite_s = 2'b01;
          C_SH:    memwrite_s = 2'b10;
          C_SB:    memwrite_s = 2'b11;
          default: memwrite_s = 2'b00;
        endcase
      end
      S_EXECUTE: begin alusrca = 1'b1; aluop = ALU_FN; end
      S_ALUWB:   begin regdst = 1'b1; regwrite_s = 1'b1; end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (class_q)
          C_ORI:   aluop = ALU_OR;
          C_ANDI:  aluop = ALU_AND;
          C_XORI:  aluop = ALU_XOR;
          C_LUI:   aluop = ALU_LUI;
          C_SLTI:  aluop = ALU_SLT;
          default: aluop = ALU_ADD;
        endcase
      end
      S_IMMWB:   regwrite_s = 1'b1;
      S_BRANCH: begin
        alusrca = 1'b1;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        aluop   = (class_q == C_BLEZ) ? ALU_BLEZ : ALU_SUB;
        ne      = (class_q == C_BNE);
      end
      S_JUMP: begin
        pcwrite_s  = 1'b1;
        pcsrc      = 2'b10;
        link       = (class_q == C_JAL);
        regwrite_s = (class_q == C_JAL);
      end
      S_JR:      begin pcwrite_s = 1'b1; pcsrc = 2'b11; jr = 1'b1; end
      S_MULT: begin
        alusrca = 1'b1;
        aluop   = ALU_FN;
`ifdef MULT_ITER_EN
        spregwrite_s = (cnt_q == '0);
`else
        spregwrite_s = 1'b1;
`endif
      end
      default: pcwrite_s = 1'b0;
    endcase
  end

  assign pcwrite    = pcwrite_s    & ~reset;
  assign irwrite    = irwrite_s    & ~reset;
  assign regwrite   = regwrite_s   & ~reset;
  assign spregwrite = spregwrite_s & ~reset;
  assign illegal    = illegal_s    & ~reset;
  assign memwrite   = reset ? 2'b00 : memwrite_s;
  assign busy       = (state_q != S_FETCH);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl; per-cycle output images are hand-derived.
module tb_multicycle_ctrl;

`ifdef MULT_ITER_EN
  localparam int MC = 4;
`else
  localparam int MC = 1;
`endif

  logic clk = 1'b0;
  logic reset, mem_ready;
  logic [5:0] op, funct;
  logic pcwrite, branch, ne, irwrite, iord, memtoreg, regdst, regwrite, alusrca;
  logic [1:0] memwrite, alusrcb, pcsrc;
  logic [3:0] aluop;
  logic half, b, lbu, link, jr, spregwrite, busy, illegal;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ALUOP_W(4), .MULT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .ne(ne), .irwrite(irwrite), .iord(iord),
    .memwrite(memwrite), .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .half(half), .b(b), .lbu(lbu), .link(link), .jr(jr),
    .spregwrite(spregwrite), .busy(busy), .illegal(illegal)
  );

  typedef struct packed {
    logic       pcwrite, branch, ne, irwrite, iord;
    logic [1:0] memwrite;
    logic       memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluop;
    logic       half, b, lbu, link, jr, spregwrite, busy, illegal;
  } out_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mr;
    out_t       exp;
  } vec_t;

  out_t obs;
  always_comb begin
    obs.pcwrite = pcwrite; obs.branch = branch; obs.ne = ne; obs.irwrite = irwrite;
    obs.iord = iord; obs.memwrite = memwrite; obs.memtoreg = memtoreg; obs.regdst = regdst;
    obs.regwrite = regwrite; obs.alusrca = alusrca; obs.alusrcb = alusrcb; obs.pcsrc = pcsrc;
    obs.aluop = aluop; obs.half = half; obs.b = b; obs.lbu = lbu; obs.link = link;
    obs.jr = jr; obs.spregwrite = spregwrite; obs.busy = busy; obs.illegal = illegal;
  end

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  out_t E_FW, E_FR, E_DEC, E_DILL, E_EXEC, E_ALUWB, E_MADR, E_MRD, E_WBLW, E_WBLB;
  out_t E_SB, E_SH, E_SW, E_WRRST, E_BNE, E_JAL, E_JR, E_ORI, E_IMMWB, E_MUL, E_MULF;

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic m, input out_t e);
    vec_t v;
    v.rst = r; v.op = o; v.funct = f; v.mr = m; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input string nm, input logic r, input logic [5:0] o,
                      input logic [5:0] f, input logic m, input out_t e);
    @(negedge clk);
    reset = r; op = o; funct = f; mem_ready = m;
    #1;
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL %s: outputs got %h want %h", nm, obs, e);
    end
  endtask

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; mem_ready = 1'b0;

    E_FW = '0;  E_FW.alusrcb = 2'b01;
    E_FR = E_FW; E_FR.irwrite = 1'b1; E_FR.pcwrite = 1'b1;
    E_DEC = '0; E_DEC.alusrcb = 2'b11; E_DEC.busy = 1'b1;
    E_DILL = E_DEC; E_DILL.illegal = 1'b1;
    E_EXEC = '0; E_EXEC.alusrca = 1'b1; E_EXEC.aluop = 4'b1111; E_EXEC.busy = 1'b1;
    E_ALUWB = '0; E_ALUWB.regdst = 1'b1; E_ALUWB.regwrite = 1'b1; E_ALUWB.busy = 1'b1;
    E_MADR = '0; E_MADR.alusrca = 1'b1; E_MADR.alusrcb = 2'b10; E_MADR.busy = 1'b1;
    E_MRD = '0; E_MRD.iord = 1'b1; E_MRD.busy = 1'b1;
    E_WBLW = '0; E_WBLW.memtoreg = 1'b1; E_WBLW.regwrite = 1'b1; E_WBLW.busy = 1'b1;
    E_WBLB = E_WBLW; E_WBLB.half = 1'b1; E_WBLB.b = 1'b1;
    E_WRRST = E_MRD;
    E_SB = E_MRD; E_SB.memwrite = 2'b11;
    E_SH = E_MRD; E_SH.memwrite = 2'b10;
    E_SW = E_MRD; E_SW.memwrite = 2'b01;
    E_BNE = '0; E_BNE.alusrca = 1'b1; E_BNE.branch = 1'b1; E_BNE.ne = 1'b1;
    E_BNE.pcsrc = 2'b01; E_BNE.aluop = 4'b0001; E_BNE.busy = 1'b1;
    E_JAL = '0; E_JAL.pcwrite = 1'b1; E_JAL.pcsrc = 2'b10; E_JAL.link = 1'b1;
    E_JAL.regwrite = 1'b1; E_JAL.busy = 1'b1;
    E_JR = '0; E_JR.pcwrite = 1'b1; E_JR.pcsrc = 2'b11; E_JR.jr = 1'b1; E_JR.busy = 1'b1;
    E_ORI = E_MADR; E_ORI.aluop = 4'b0011;
    E_IMMWB = '0; E_IMMWB.regwrite = 1'b1; E_IMMWB.busy = 1'b1;
    E_MUL = E_EXEC;
    E_MULF = E_EXEC; E_MULF.spregwrite = 1'b1;

    // reset held with mem_ready=1: strobes forced low
    add(1'b1, 6'o00, 6'o00, 1'b1, E_FW);
    // add
    add(1'b0, 6'b000000, 6'b100000, 1'b1, E_FR);
    add(1'b0, 6'b000000, 6'b100000, 1'b0, E_DEC);
    add(1'b0, 6'b000000, 6'b100000, 1'b0, E_EXEC);
    add(1'b0, 6'b000000, 6'b100000, 1'b0, E_ALUWB);
    // lw with fetch stall and three MEMRD stalls; IR changes after DECODE
    add(1'b0, 6'b100011, 6'b000000, 1'b0, E_FW);
    add(1'b0, 6'b100011, 6'b000000, 1'b1, E_FR);
    add(1'b0, 6'b100011, 6'b000000, 1'b1, E_DEC);
    add(1'b0, 6'b100011, 6'b000000, 1'b1, E_MADR);
    add(1'b0, 6'b111111, 6'b000000, 1'b0, E_MRD);
    add(1'b0, 6'b111111, 6'b000000, 1'b0, E_MRD);
    add(1'b0, 6'b111111, 6'b000000, 1'b0, E_MRD);
    add(1'b0, 6'b111111, 6'b000000, 1'b1, E_MRD);
    add(1'b0, 6'b111111, 6'b000000, 1'b0, E_WBLW);
    // sb with two MEMWR stalls
    add(1'b0, 6'b101000, 6'b000000, 1'b1, E_FR);
    add(1'b0, 6'b101000, 6'b000000, 1'b0, E_DEC);
    add(1'b0, 6'b101000, 6'b000000, 1'b0, E_MADR);
    add(1'b0, 6'b101000, 6'b000000, 1'b0, E_SB);
    add(1'b0, 6'b101000, 6'b000000, 1'b0, E_SB);
    add(1'b0, 6'b101000, 6'b000000, 1'b1, E_SB);
    // sh
    add(1'b0, 6'b101001, 6'b000000, 1'b1, E_FR);
    add(1'b0, 6'b101001, 6'b000000, 1'b0, E_DEC);
    add(1'b0, 6'b101001, 6'b000000, 1'b0, E_MADR);
    add(1'b0, 6'b101001, 6'b000000, 1'b1, E_SH);
    // bne, jal
    add(1'b0, 6'b000101, 6'b000000, 1'b1, E_FR);
    add(1'b0, 6'b000101, 6'b000000, 1'b0, E_DEC);
    add(1'b0, 6'b000101, 6'b000000, 1'b1, E_BNE);
    add(1'b0, 6'b000011, 6'b000000, 1'b1, E_FR);
    add(1'b0, 6'b000011, 6'b000000, 1'b0, E_DEC);
    add(1'b0, 6'b000011, 6'b000000, 1'b1, E_JAL);
    // illegal opcode pulses once then FETCH
    add(1'b0, 6'b111111, 6'b000000, 1'b1, E_FR);
    add(1'b0, 6'b111111, 6'b000000, 1'b0, E_DILL);
    add(1'b0, 6'b111111, 6'b000000, 1'b0, E_FW);
    // ori, lb, jr
    add(1'b0, 6'b001101, 6'b000000, 1'b1, E_FR);
    add(1'b0, 6'b001101, 6'b000000, 1'b0, E_DEC);
    add(1'b0, 6'b001101, 6'b000000, 1'b0, E_ORI);
    add(1'b0, 6'b001101, 6'b000000, 1'b0, E_IMMWB);
    add(1'b0, 6'b100000, 6'b000000, 1'b1, E_FR);
    add(1'b0, 6'b100000, 6'b000000, 1'b0, E_DEC);
    add(1'b0, 6'b100000, 6'b000000, 1'b0, E_MADR);
    add(1'b0, 6'b100000, 6'b000000, 1'b1, E_MRD);
    add(1'b0, 6'b100000, 6'b000000, 1'b0, E_WBLB);
    add(1'b0, 6'b000000, 6'b001000, 1'b1, E_FR);
    add(1'b0, 6'b000000, 6'b001000, 1'b0, E_DEC);
    add(1'b0, 6'b000000, 6'b001000, 1'b1, E_JR);

    repeat (2) @(posedge clk);
    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].mr, vecs[i].exp);

    // mult: spregwrite only in the last MULT cycle
    step("mult_fetch", 1'b0, 6'b000000, 6'b011000, 1'b1, E_FR);
    step("mult_decode", 1'b0, 6'b000000, 6'b011000, 1'b0, E_DEC);
    for (int k = 0; k < MC; k++)
      step($sformatf("mult_cyc%0d", k), 1'b0, 6'b000000, 6'b011000, 1'b1,
           (k == MC - 1) ? E_MULF : E_MUL);
    step("mult_done", 1'b0, 6'b000000, 6'b000000, 1'b0, E_FW);

    // sw interrupted by reset in MEMWR
    step("sw_fetch", 1'b0, 6'b101011, 6'b000000, 1'b1, E_FR);
    step("sw_decode", 1'b0, 6'b101011, 6'b000000, 1'b0, E_DEC);
    step("sw_memadr", 1'b0, 6'b101011, 6'b000000, 1'b0, E_MADR);
    step("sw_memwr", 1'b0, 6'b101011, 6'b000000, 1'b0, E_SW);
    step("sw_reset", 1'b1, 6'b101011, 6'b000000, 1'b0, E_WRRST);
    step("sw_after_reset", 1'b0, 6'b101011, 6'b000000, 1'b0, E_FW);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Parametrised control FSM for the multicycle MIPS core. Replaces the single-cycle main decoder.
- Decodes op/funct once per instruction and sequences FETCH → DECODE → execute/memory/writeback states.
- Drives datapath enables, mux selects and ALU op per state.
- Adds memory-ready handshake stalls and an iterative multiply wait, neither of which the single-cycle decoder supports.

Parameters:
- ALUOP_W, 4, width of aluop output.
- MULT_CYCLES, 32, cycles the multiplier needs before HI/LO write (≥1).
- CNT_W, $clog2(MULT_CYCLES+1), multiply counter width (derived, do not override).

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous active-high reset
- op  input  6  instruction[31:26], valid from DECODE onward (IR)
- funct  input  6  instruction[5:0]
- mem_ready  input  1  memory completes current access this cycle
- pcwrite  output  1  unconditional PC write
- branch  output  1  conditional PC write (datapath: pcen = pcwrite | branch & cond)
- ne  output  1  invert branch condition (bne)
- irwrite  output  1  IR load
- iord  output  1  memory address from ALUOut (1) or PC (0)
- memwrite  output  2  00 none, 01 word, 10 half, 11 byte
- memtoreg  output  1  writeback from MDR
- regdst  output  1  rd (1) / rt (0)
- regwrite  output  1  register file write
- alusrca  output  1  A from register (1) / PC (0)
- alusrcb  output  2  00 B, 01 const 4, 10 signimm, 11 signimm<<2
- pcsrc  output  2  00 ALU, 01 ALUOut, 10 jump target, 11 register (jr)
- aluop  output  ALUOP_W  ALU operation code
- half, b, lbu  output  1 each  load size/sign select (MEMWB only)
- link  output  1  write PC+4 to $ra
- jr  output  1  jump-register indicator
- spregwrite  output  1  HI/LO write strobe
- busy  output  1  high when state ≠ FETCH
- illegal  output  1  one-cycle pulse on unknown opcode

Behaviour:
- Moore outputs decoded from state. Unlisted outputs are 0 in each state.
- aluop codes: add 0000, sub 0001, blez 0010, or 0011, lui 0100, xor 0101, slt 0110, and 0111, funct-decode 1111. Zero-extend to ALUOP_W.
- Reset: at the clk edge with reset=1, state←FETCH, counter←0, op-class register←0. While reset=1, pcwrite/irwrite/regwrite/memwrite/spregwrite/illegal are forced 0. Reset mid-instruction abandons the instruction with no writes.
- FETCH:
  - Outputs: iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00.
  - irwrite and pcwrite are asserted only when mem_ready=1. Then go to DECODE; otherwise stay in FETCH.
- DECODE:
  - Outputs: alusrcb=11, aluop=add.
  - Next state by op: lw/lh/lb/lbu/sw/sh/sb → MEMADR; op=0 & funct=001000 → JR; op=0 & funct=011000 → MULT; other op=0 → EXECUTE; addi/ori/andi/xori/lui/slti → IMMEX; beq/bne/blez → BRANCH; j/jal → JUMP.
  - Any other op: illegal=1 for one cycle, go to FETCH.
- MEMADR: alusrca=1, alusrcb=10, aluop=add. Loads → MEMRD; stores → MEMWR.
- MEMRD: iord=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: memtoreg=1, regwrite=1. lh: half=1. lb: half=1, b=1. lbu: lbu=1. Then → FETCH.
- MEMWR: iord=1, memwrite=01/10/11 for sw/sh/sb. Held stable until mem_ready=1, then → FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=1111. Then → ALUWB.
- ALUWB: regdst=1, regwrite=1. Then → FETCH.
- IMMEX: alusrca=1, alusrcb=10, aluop per op (addi add, ori or, andi and, xori xor, lui lui, slti slt). Then → IMMWB.
- IMMWB: regwrite=1, regdst=0. Then → FETCH.
- BRANCH: alusrca=1, alusrcb=00, branch=1, pcsrc=01. aluop=sub for beq/bne, blez for blez; ne=1 for bne. Then → FETCH.
- JUMP: pcwrite=1, pcsrc=10. jal additionally asserts link=1 and regwrite=1. Then → FETCH.
- JR: pcwrite=1, pcsrc=11, jr=1. Then → FETCH.
- MULT: alusrca=1, alusrcb=00, aluop=1111. Behaviour depends on the macro (see Optional Feature).
- op/funct are sampled only in DECODE. Class is latched for use in later states, so IR changes after DECODE have no effect.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.

Optional Feature:
- Macro: MULT_ITER_EN.
- Defined:
  - On MULT entry the counter loads MULT_CYCLES-1 and decrements each cycle.
  - When the counter is 0, spregwrite=1 for exactly that cycle, then → FETCH.
  - Total MULT residency is MULT_CYCLES cycles.
- Undefined: MULT asserts spregwrite=1 in its single cycle, then → FETCH. No counter is synthesised.

Test Plan:
- add (op=0, funct=100000), mem_ready=1 → states FETCH, DECODE, EXECUTE, ALUWB; regwrite=1 and regdst=1 in ALUWB only; 4 cycles.
- lw (op=100011), mem_ready held 0 for 3 cycles in MEMRD → stays in MEMRD 4 cycles, iord=1 throughout; MEMWB memtoreg=1, regwrite=1.
- sb (op=101000) → memwrite=11 held in MEMWR until mem_ready=1, then FETCH. Same with sh gives memwrite=10.
- bne (op=000101) → BRANCH with branch=1, ne=1, aluop=0001, pcsrc=01. jal (op=000011) → pcsrc=10, link=1, regwrite=1.
- mult with MULT_ITER_EN, MULT_CYCLES=4 → spregwrite high exactly in 4th MULT cycle. Without the macro → high in first MULT cycle.
- op=111111 → illegal pulses 1 cycle, return to FETCH. Reset asserted mid-MEMWR → memwrite=0 immediately, state FETCH next cycle.
